// File: rtl/instr_decode_buffer.sv
// Instruction FIFO feeding a registered MIPS field splitter; push-to-dec_valid latency is 2 cycles.
// Output registers hold while dec_valid && !dec_ready; instr_ready drops only when the FIFO is full.
module instr_decode_buffer #(
  parameter int                   DEPTH        = 4,
  parameter int                   XLEN         = 32,
  parameter int                   STATE_W      = 3,
  parameter logic [STATE_W-1:0]   DECODE_STATE = 3'd1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [STATE_W-1:0]         state,
  input  logic                       flush,
  input  logic                       instr_valid,
  input  logic [31:0]                instr,
  output logic                       instr_ready,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [XLEN-1:0]            imm_ext,
  output logic [25:0]                jaddr,
  output logic                       is_rtype,
  output logic                       is_jtype,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            dec_valid_q;
  logic [5:0]      opcode_q, funct_q;
  logic [4:0]      rs_q, rt_q, rd_q, shamt_q;
  logic [XLEN-1:0] imm_ext_q, imm_ext_d;
  logic [25:0]     jaddr_q;
  logic            is_rtype_q, is_jtype_q;

  logic            push, load;
  logic [31:0]     head_w;
  logic [15:0]     head_imm;

  assign instr_ready = RST && (count_q != CW'(DEPTH));
  assign push        = instr_valid && instr_ready;
  assign load        = (state == DECODE_STATE) && (count_q != '0) && (!dec_valid_q || dec_ready);

  assign head_w   = mem_q[rd_ptr_q];
  assign head_imm = head_w[15:0];

  // Logical ops take an unsigned immediate, lui places it in the upper half.
  always_comb begin
    imm_ext_d = XLEN'($signed(head_imm));
    case (head_w[31:26])
      6'h0C, 6'h0D, 6'h0E: imm_ext_d = XLEN'(head_imm);
      6'h0F:               imm_ext_d = XLEN'({head_imm, 16'h0000});
      default:             imm_ext_d = XLEN'($signed(head_imm));
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !load)      count_d = count_q + CW'(1);
    else if (load && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) mem_q[wr_ptr_q] <= instr;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      opcode_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      shamt_q     <= '0;
      funct_q     <= '0;
      imm_ext_q   <= '0;
      jaddr_q     <= '0;
      is_rtype_q  <= 1'b0;
      is_jtype_q  <= 1'b0;
    end else if (flush) begin
      // Field registers keep their last values; only the valid bit and queue state are dropped.
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        dec_valid_q <= 1'b1;
        opcode_q    <= head_w[31:26];
        rs_q        <= head_w[25:21];
        rt_q        <= head_w[20:16];
        rd_q        <= head_w[15:11];
        shamt_q     <= head_w[10:6];
        funct_q     <= head_w[5:0];
        imm_ext_q   <= imm_ext_d;
        jaddr_q     <= head_w[25:0];
        is_rtype_q  <= (head_w[31:26] == 6'h00);
        is_jtype_q  <= (head_w[31:26] == 6'h02) || (head_w[31:26] == 6'h03);
      end else if (dec_valid_q && dec_ready) begin
        dec_valid_q <= 1'b0;
      end
    end
  end

  assign dec_valid = dec_valid_q;
  assign opcode    = opcode_q;
  assign rs        = rs_q;
  assign rt        = rt_q;
  assign rd        = rd_q;
  assign shamt     = shamt_q;
  assign funct     = funct_q;
  assign imm_ext   = imm_ext_q;
  assign jaddr     = jaddr_q;
  assign is_rtype  = is_rtype_q;
  assign is_jtype  = is_jtype_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Directed bench for instr_decode_buffer: vector table for field/immediate decode, then hand sequences.
module tb_instr_decode_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  state;
  logic        flush;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;
  logic        is_rtype, is_jtype;
  logic [2:0]  count;

  always #5 CLK = ~CLK;

  instr_decode_buffer #(.DEPTH(4), .XLEN(32), .STATE_W(3), .DECODE_STATE(3'd1)) dut (
    .CLK(CLK), .RST(RST), .state(state), .flush(flush),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_ext(imm_ext), .jaddr(jaddr), .is_rtype(is_rtype), .is_jtype(is_jtype),
    .count(count)
  );

  typedef struct {
    logic [31:0] w;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [25:0] ja;
    logic        rf, jf;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] wrap_w [6];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    instr_valid = 1'b1;
    instr       = w;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic expect_word(input string nm, input logic [31:0] w);
    chk({nm, "_valid"}, 64'(dec_valid), 64'd1);
    chk({nm, "_word"}, 64'({opcode, jaddr}), 64'(w));
  endtask

  initial begin
    vecs[0] = '{32'h012A4020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 26'h12A4020, 1'b1, 1'b0};
    vecs[1] = '{32'h2128FFFF, 6'h08, 5'd9, 5'd8,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 26'h128FFFF, 1'b0, 1'b0};
    vecs[2] = '{32'h3528FFFF, 6'h0D, 5'd9, 5'd8,  5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 26'h128FFFF, 1'b0, 1'b0};
    vecs[3] = '{32'h3C08ABCD, 6'h0F, 5'd0, 5'd8,  5'd21, 5'd15, 6'h0D, 32'hABCD0000, 26'h008ABCD, 1'b0, 1'b0};
    vecs[4] = '{32'h0C000010, 6'h03, 5'd0, 5'd0,  5'd0,  5'd0,  6'h10, 32'h00000010, 26'h0000010, 1'b0, 1'b1};
    vecs[5] = '{32'h39088000, 6'h0E, 5'd8, 5'd8,  5'd16, 5'd0,  6'h00, 32'h00008000, 26'h1088000, 1'b0, 1'b0};
    vecs[6] = '{32'h08000003, 6'h02, 5'd0, 5'd0,  5'd0,  5'd0,  6'h03, 32'h00000003, 26'h0000003, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) wrap_w[i] = 32'h20000100 + 32'(i);

    RST = 1'b0; state = 3'd0; flush = 1'b0; instr_valid = 1'b0; instr = '0; dec_ready = 1'b0;
    step();
    step();
    chk("rst_instr_ready", 64'(instr_ready), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_fields", 64'({opcode, rs, rt, rd, shamt, funct, jaddr, is_rtype, is_jtype}), 64'd0);
    chk("rst_imm_ext", 64'(imm_ext), 64'd0);
    RST = 1'b1;
    #1;
    chk("ready_after_rst", 64'(instr_ready), 64'd1);

    // Field and immediate decode table: push, one idle edge, then the decode edge.
    state = 3'd1; dec_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_word(vecs[i].w);
      chk($sformatf("v%0d_no_bypass", i), 64'(dec_valid), 64'd0);
      step();
      chk($sformatf("v%0d_valid", i), 64'(dec_valid), 64'd1);
      chk($sformatf("v%0d_regs", i), 64'({opcode, rs, rt, rd, shamt, funct}),
          64'({vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].fn}));
      chk($sformatf("v%0d_imm_ext", i), 64'(imm_ext), 64'(vecs[i].imm));
      chk($sformatf("v%0d_jaddr", i), 64'(jaddr), 64'(vecs[i].ja));
      chk($sformatf("v%0d_flags", i), 64'({is_rtype, is_jtype}), 64'({vecs[i].rf, vecs[i].jf}));
      step();
      chk($sformatf("v%0d_valid_drop", i), 64'(dec_valid), 64'd0);
    end

    // Fill with decode gated off, refuse a fifth push, then drain across the pointer wrap.
    state = 3'd0;
    for (int i = 0; i < 4; i++) push_word(wrap_w[i]);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(instr_ready), 64'd0);
    push_word(32'hDEADBEEF);
    chk("full_push_refused", 64'(count), 64'd4);
    chk("gated_no_load", 64'(dec_valid), 64'd0);
    begin
      int   pushed = 4;
      int   got = 0;
      logic pre_rdy;
      state = 3'd1; dec_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
        instr_valid = (pushed < 6);
        instr       = (pushed < 6) ? wrap_w[pushed] : 32'h0;
        pre_rdy     = instr_ready;
        step();
        if (instr_valid && pre_rdy) pushed++;
        if (dec_valid) begin
          chk($sformatf("wrap_order_%0d", got), 64'({opcode, jaddr}), 64'(wrap_w[got]));
          got++;
        end
      end
      instr_valid = 1'b0;
      chk("wrap_all_received", 64'(got), 64'd6);
      chk("wrap_count_empty", 64'(count), 64'd0);
    end
    step();
    chk("wrap_idle", 64'(dec_valid), 64'd0);

    // Back-pressure holds outputs, then state gating blocks loads.
    state = 3'd0;
    push_word(32'h2001AAAA);
    push_word(32'h2002BBBB);
    state = 3'd1; dec_ready = 1'b0;
    step();
    expect_word("bp_load", 32'h2001AAAA);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_word($sformatf("bp_hold%0d", i), 32'h2001AAAA);
      chk($sformatf("bp_imm%0d", i), 64'(imm_ext), 64'hFFFFAAAA);
      chk($sformatf("bp_count%0d", i), 64'(count), 64'd1);
    end
    state = 3'd0; dec_ready = 1'b1;
    step();
    chk("gate_consume_valid", 64'(dec_valid), 64'd0);
    chk("gate_consume_count", 64'(count), 64'd1);
    step();
    chk("gate_idle_valid", 64'(dec_valid), 64'd0);
    chk("gate_fields_hold", 64'({opcode, jaddr}), 64'h2001AAAA);
    state = 3'd1;
    step();
    expect_word("gate_release", 32'h2002BBBB);
    chk("gate_release_count", 64'(count), 64'd0);
    step();

    // Simultaneous push and load at count 2.
    state = 3'd0;
    push_word(32'h20030001);
    push_word(32'h20030002);
    chk("sim_pre_count", 64'(count), 64'd2);
    state = 3'd1; dec_ready = 1'b1;
    push_word(32'h20030003);
    chk("sim_count", 64'(count), 64'd2);
    expect_word("sim_p0", 32'h20030001);
    step();
    expect_word("sim_p1", 32'h20030002);
    step();
    expect_word("sim_p2", 32'h20030003);
    chk("sim_count_end", 64'(count), 64'd0);
    step();
    chk("sim_idle", 64'(dec_valid), 64'd0);

    // Flush with a concurrent push (and an enabled load) discards everything.
    state = 3'd0;
    push_word(32'h20040001);
    push_word(32'h20040002);
    push_word(32'h20040003);
    chk("fl_pre_count", 64'(count), 64'd3);
    flush = 1'b1; state = 3'd1;
    push_word(32'h20040004);
    flush = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(dec_valid), 64'd0);
    chk("fl_fields_hold", 64'({opcode, jaddr}), 64'h20030003);
    step();
    step();
    chk("fl_not_stored_valid", 64'(dec_valid), 64'd0);
    chk("fl_not_stored_count", 64'(count), 64'd0);

    // Reset in the middle of traffic.
    dec_ready = 1'b0;
    push_word(32'h0C000010);
    push_word(32'h2005CCCC);
    expect_word("mr_loaded", 32'h0C000010);
    RST = 1'b0;
    #1;
    chk("mr_ready_low", 64'(instr_ready), 64'd0);
    step();
    chk("mr_valid", 64'(dec_valid), 64'd0);
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_fields", 64'({opcode, rs, rt, rd, shamt, funct, jaddr, is_rtype, is_jtype}), 64'd0);
    chk("mr_imm_ext", 64'(imm_ext), 64'd0);
    push_word(32'h2006DDDD);
    chk("mr_push_blocked_ready", 64'(instr_ready), 64'd0);
    chk("mr_push_blocked_count", 64'(count), 64'd0);
    RST = 1'b1;
    #1;
    chk("mr_ready_back", 64'(instr_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
